// File: rtl/sample_feeder_if.sv
// Sample feeder bus: training-run control, neuron handshake, sample memory
// port and run status, seen from the feeder (slave) and its user (master).
interface sample_feeder_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int EPOCH_W = 8
);
  logic                start;
  logic                req;
  logic                upd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [2*DATA_W:0]   mem_rdata;
  logic [DATA_W-1:0]   x1;
  logic [DATA_W-1:0]   x2;
  logic                t;
  logic                data_ready;
  logic                eof;
  logic                end_flag;
  logic [EPOCH_W-1:0]  epoch_cnt;
  logic                busy;
  logic                done;

  modport master (
    output start, req, upd, mem_rdata,
    input  mem_addr, x1, x2, t, data_ready, eof, end_flag, epoch_cnt, busy, done
  );

  modport slave (
    input  start, req, upd, mem_rdata,
    output mem_addr, x1, x2, t, data_ready, eof, end_flag, epoch_cnt, busy, done
  );
endinterface

// File: rtl/sample_feeder.sv
// Sample feeder: walks a small sample memory once per epoch, handing one
// {t, x1, x2} sample to the neuron per request, and repeats epochs while the
// neuron keeps updating its weights, up to an epoch limit.
module sample_feeder #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int N_SAMPLES  = 4,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = 16
) (
  input  logic           clk,
  input  logic           rst,
  sample_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, READ, LATCH, READY, DONE} state_t;

  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0]  IDX_ONE    = ADDR_W'(1);
  localparam logic [EPOCH_W:0]   EPOCH_ONE  = (EPOCH_W + 1)'(1);
  localparam logic [EPOCH_W:0]   MAX_EP     = (EPOCH_W + 1)'(MAX_EPOCHS);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCHS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [EPOCH_W:0]    epochInc;
  logic                dirty_q, dirty_d;
  logic [DATA_W-1:0]   x1_q, x2_q;
  logic                t_q, eof_q;
  logic                data_ready_q, end_flag_q, busy_q, done_q;

  function automatic logic isBusy(input state_t s);
    return (s == WAIT_REQ) || (s == READ) || (s == LATCH) || (s == READY);
  endfunction

  // Next-state, sample index, epoch count and weight-update tracking.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    epoch_d  = epoch_q;
    dirty_d  = dirty_q;
    epochInc = {1'b0, epoch_q} + EPOCH_ONE;
    if (bus.upd && isBusy(state_q)) dirty_d = 1'b1;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = WAIT_REQ;
          idx_d   = '0;
          epoch_d = '0;
          dirty_d = 1'b0;
        end
      end
      WAIT_REQ: begin
        if (bus.req) begin
          state_d = READ;
          if (idx_q == '0) dirty_d = bus.upd;
        end
      end
      READ:  state_d = LATCH;
      LATCH: state_d = READY;
      READY: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          epoch_d = epochInc[EPOCH_W-1:0];
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
        if (eof_q && ((epochInc >= MAX_EP) || !(dirty_q || bus.upd))) state_d = DONE;
        else state_d = WAIT_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered sample and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      epoch_q      <= '0;
      dirty_q      <= 1'b0;
      x1_q         <= '0;
      x2_q         <= '0;
      t_q          <= 1'b0;
      eof_q        <= 1'b0;
      data_ready_q <= 1'b0;
      end_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      dirty_q <= dirty_d;
      if (state_q == LATCH) begin
        t_q   <= bus.mem_rdata[2*DATA_W];
        x1_q  <= bus.mem_rdata[2*DATA_W-1:DATA_W];
        x2_q  <= bus.mem_rdata[DATA_W-1:0];
        eof_q <= (idx_q == LAST_IDX);
      end
      data_ready_q <= (state_d == READY);
      end_flag_q   <= dirty_q && (epoch_q < LAST_EPOCH);
      busy_q       <= isBusy(state_d);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.mem_addr   = idx_q;
  assign bus.x1         = x1_q;
  assign bus.x2         = x2_q;
  assign bus.t          = t_q;
  assign bus.eof        = eof_q;
  assign bus.data_ready = data_ready_q;
  assign bus.end_flag   = end_flag_q;
  assign bus.epoch_cnt  = epoch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
